// File: rtl/kbd_port_pkg.sv
// kbd_port_pkg: shared constants for the keyboard port FIFO.
//   - PS/2 prefix bytes (break, extended)
//   - status byte bit positions, control byte bit positions
//   - prefix FSM state encoding
package kbd_port_pkg;

  localparam logic [7:0] KBD_PFX_BREAK = 8'hF0;
  localparam logic [7:0] KBD_PFX_EXT0  = 8'hE0;
  localparam logic [7:0] KBD_PFX_EXT1  = 8'hE1;

  // status byte: {nonempty, overflow, count[5:0]}
  localparam int STAT_NONEMPTY = 7;
  localparam int STAT_OVF      = 6;
  localparam int STAT_CNT_W    = 6;

  // control byte
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_INTR_EN = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BRK  = 1'b1
  } pfx_state_e;

endpackage

// File: rtl/kbd_fifo_core.sv
// kbd_fifo_core: synchronous DEPTH x 8 FIFO.
//   clk, reset_n    clock, async active-low reset
//   push, pop       requests; push while full is dropped unless a pop
//                   frees the slot in the same cycle; pop while empty ignored
//   flush           empties the FIFO, overrides push/pop
//   din / dout      write data / head entry (dout undefined when empty)
//   full, empty     flags
//   count           current occupancy, count_nxt is next-cycle occupancy
module kbd_fifo_core #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop on a full FIFO frees the slot the push lands in
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count + CW'(do_push) - CW'(do_pop);
    if (flush) count_nxt = '0;
  end

  // pointers are AW bits wide, so DEPTH (power of two) wraps for free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/kbd_port_fifo.sv
// kbd_port_fifo: buffers decoded PS/2 key events for the CPU port bus.
//   clk, reset_n          clock, async active-low reset
//   code_in, ascii_in     raw scan byte and its translation, valid on code_valid
//   pin_pa, pin_rd        port address / read strobe (read of PORT_DATA pops)
//   pin_pw, pin_po        port write strobe / data (control at PORT_STAT)
//   pin_pi                combinational read data
//   intr                  level interrupt: intr_en & FIFO nonempty
// Optional: define KBD_PORT_TYPEMATIC_FILTER_EN to drop auto-repeated makes.
module kbd_port_fifo
  import kbd_port_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] PORT_DATA = 8'hFE,
  parameter logic [7:0] PORT_STAT = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] code_in,
  input  logic [7:0] ascii_in,
  input  logic       code_valid,
  input  logic [7:0] pin_pa,
  input  logic       pin_pw,
  input  logic [7:0] pin_po,
  input  logic       pin_rd,
  output logic [7:0] pin_pi,
  output logic       intr
);

  localparam int CW = $clog2(DEPTH) + 1;

  pfx_state_e    state_q, state_d;
  logic          ctrl_wr, flush, clr_ovf, pop_req;
  logic          is_ext, is_key, passthru, push;
  logic [7:0]    entry, head;
  logic          full, empty, overflow, ovf_set;
  logic          intr_en, intr_en_d;
  logic [CW-1:0] count, count_nxt;
  logic [7:0]    stat;
  logic          unused_po;

  assign unused_po = &{1'b0, pin_po[6:2]};

  assign ctrl_wr = pin_pw & (pin_pa == PORT_STAT);
  assign flush   = ctrl_wr & pin_po[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr & pin_po[CTRL_CLR_OVF];
  assign pop_req = pin_rd & (pin_pa == PORT_DATA);

  assign is_ext = (code_in == KBD_PFX_EXT0) | (code_in == KBD_PFX_EXT1);
  assign is_key = code_valid & (code_in != KBD_PFX_BREAK) & ~is_ext;

  // E-class translations are special keys that carry their own meaning in
  // bit 7, so they bypass the break flag
  assign passthru = (ascii_in[7:4] == 4'hE);
  assign entry    = passthru ? ascii_in : {state_q == ST_BRK, ascii_in[6:0]};

`ifdef KBD_PORT_TYPEMATIC_FILTER_EN
  logic [7:0] last_make;
  logic       lm_vld, is_make, is_brk, drop;

  assign is_make = is_key & ~passthru & (state_q == ST_IDLE);
  assign is_brk  = is_key & ~passthru & (state_q == ST_BRK);
  assign drop    = is_make & lm_vld & (entry == last_make);
  assign push    = is_key & ~drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_make <= '0;
      lm_vld    <= 1'b0;
    end else if (flush) begin
      lm_vld <= 1'b0;
    end else if (is_make && !drop) begin
      last_make <= entry;
      lm_vld    <= 1'b1;
    end else if (is_brk && entry[6:0] == last_make[6:0]) begin
      lm_vld <= 1'b0;
    end
  end
`else
  assign push = is_key;
`endif

  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      if (code_in == KBD_PFX_BREAK) state_d = ST_BRK;
      else if (!is_ext)             state_d = ST_IDLE;
    end
    if (flush) state_d = ST_IDLE;
  end

  kbd_fifo_core #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop_req),
    .flush     (flush),
    .din       (entry),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // a coincident pop makes room, and a flush discards the code outright
  assign ovf_set = push & full & ~pop_req & ~flush;

  assign intr_en_d = ctrl_wr ? pin_po[CTRL_INTR_EN] : intr_en;

  // intr is built from next-cycle occupancy so it tracks the FIFO edge
  // the CPU sees rather than lagging a further cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      overflow <= 1'b0;
      intr_en  <= 1'b0;
      intr     <= 1'b0;
    end else begin
      state_q <= state_d;
      intr_en <= intr_en_d;
      intr    <= intr_en_d & (count_nxt != '0);
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_comb begin
    stat                   = '0;
    stat[STAT_NONEMPTY]    = ~empty;
    stat[STAT_OVF]         = overflow;
    stat[STAT_CNT_W-1:0]   = STAT_CNT_W'(count);
  end

  always_comb begin
    pin_pi = 8'hFF;
    if (pin_pa == PORT_DATA)      pin_pi = empty ? 8'h00 : head;
    else if (pin_pa == PORT_STAT) pin_pi = stat;
  end

endmodule

// File: tb/tb_kbd_port_fifo.sv
// tb_kbd_port_fifo: directed self-checking bench for kbd_port_fifo (DEPTH=16).
module tb_kbd_port_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] code_in = '0, ascii_in = '0, pin_pa = '0, pin_po = '0;
  logic       code_valid = 1'b0, pin_pw = 1'b0, pin_rd = 1'b0;
  logic [7:0] pin_pi;
  logic       intr;

  int vecs = 0;
  int errs = 0;

  kbd_port_fifo #(.DEPTH(16), .PORT_DATA(8'hFE), .PORT_STAT(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .code_in(code_in), .ascii_in(ascii_in),
    .code_valid(code_valid), .pin_pa(pin_pa), .pin_pw(pin_pw), .pin_po(pin_po),
    .pin_rd(pin_rd), .pin_pi(pin_pi), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic key(input logic [7:0] c, input logic [7:0] a);
    @(negedge clk);
    code_in = c; ascii_in = a; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic port_rd(input logic [7:0] addr, output logic [7:0] d);
    @(negedge clk);
    pin_pa = addr; pin_rd = 1'b1;
    #1 d = pin_pi;
    @(negedge clk);
    pin_rd = 1'b0;
  endtask

  task automatic port_wr(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pin_pa = addr; pin_po = data; pin_pw = 1'b1;
    @(negedge clk);
    pin_pw = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL reset_stat got %h want 00", d); end
    vecs++; if (intr !== 1'b0) begin errs++; $display("FAIL reset_intr got %b want 0", intr); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", d); end
    port_rd(8'h10, d);
    vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL other_addr got %h want FF", d); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d;
    key(8'h1C, 8'h61);
    port_wr(8'hFE, 8'h81);  // ignored
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h81) begin errs++; $display("FAIL basic_stat got %h want 81", d); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h61) begin errs++; $display("FAIL basic_data got %h want 61", d); end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL basic_stat_empty got %h want 00", d); end
  endtask

  task automatic test_prefix();
    logic [7:0] d;
    key(8'hF0, 8'h00);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL pfx_f0_nopush got %h want 00", d); end
    key(8'h1C, 8'h61);
    key(8'h69, 8'hE5);
    key(8'hE0, 8'h00);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h82) begin errs++; $display("FAIL pfx_stat got %h want 82", d); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'hE1) begin errs++; $display("FAIL pfx_break got %h want E1", d); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'hE5) begin errs++; $display("FAIL pfx_pass got %h want E5", d); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL pfx_empty_pop got %h want 00", d); end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL pfx_stat_end got %h want 00", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) key(8'(8'h10 + i), 8'(i + 1));
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'hD0) begin errs++; $display("FAIL ovf_stat got %h want D0", d); end
    for (int i = 0; i < 16; i++) begin
      port_rd(8'hFE, d);
      vecs++; if (d !== 8'(i + 1)) begin errs++; $display("FAIL ovf_order[%0d] got %h want %h", i, d, 8'(i + 1)); end
    end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h40) begin errs++; $display("FAIL ovf_drained got %h want 40", d); end
    port_wr(8'hFF, 8'h02);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL ovf_clear got %h want 00", d); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) key(8'(8'h10 + i), 8'(8'h20 + i));
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h90) begin errs++; $display("FAIL full_stat got %h want 90", d); end
    @(negedge clk);
    code_in = 8'h55; ascii_in = 8'h3A; code_valid = 1'b1;
    pin_pa = 8'hFE; pin_rd = 1'b1;
    #1 d = pin_pi;
    @(negedge clk);
    code_valid = 1'b0; pin_rd = 1'b0;
    vecs++; if (d !== 8'h20) begin errs++; $display("FAIL pushpop_head got %h want 20", d); end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h90) begin errs++; $display("FAIL pushpop_stat got %h want 90", d); end
    // overflowing push coincident with clear-overflow: overflow wins
    @(negedge clk);
    code_in = 8'h56; ascii_in = 8'h3B; code_valid = 1'b1;
    pin_pa = 8'hFF; pin_po = 8'h02; pin_pw = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; pin_pw = 1'b0;
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'hD0) begin errs++; $display("FAIL ovf_vs_clr got %h want D0", d); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h21) begin errs++; $display("FAIL pushpop_next got %h want 21", d); end
    port_wr(8'hFF, 8'h01);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h40) begin errs++; $display("FAIL flush_keep_ovf got %h want 40", d); end
    port_wr(8'hFF, 8'h02);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL flush_clr got %h want 00", d); end
  endtask

  task automatic test_intr();
    logic [7:0] d;
    port_wr(8'hFF, 8'h80);
    vecs++; if (intr !== 1'b0) begin errs++; $display("FAIL intr_en_empty got %b want 0", intr); end
    key(8'h30, 8'h41);
    vecs++; if (intr !== 1'b1) begin errs++; $display("FAIL intr_push got %b want 1", intr); end
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h41) begin errs++; $display("FAIL intr_data got %h want 41", d); end
    vecs++; if (intr !== 1'b0) begin errs++; $display("FAIL intr_pop got %b want 0", intr); end
    key(8'h31, 8'h42);
    vecs++; if (intr !== 1'b1) begin errs++; $display("FAIL intr_push2 got %b want 1", intr); end
    @(negedge clk);
    code_in = 8'h32; ascii_in = 8'h43; code_valid = 1'b1;
    pin_pa = 8'hFF; pin_po = 8'h81; pin_pw = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; pin_pw = 1'b0;
    vecs++; if (intr !== 1'b0) begin errs++; $display("FAIL intr_flush got %b want 0", intr); end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL flush_push_stat got %h want 00", d); end
    port_wr(8'hFF, 8'h00);
    // flush also returns the prefix FSM to IDLE
    key(8'hF0, 8'h00);
    port_wr(8'hFF, 8'h01);
    key(8'h1C, 8'h61);
    port_rd(8'hFE, d);
    vecs++; if (d !== 8'h61) begin errs++; $display("FAIL flush_fsm got %h want 61", d); end
  endtask

  task automatic test_typematic();
    logic [7:0] d;
    logic [7:0] exp_q[$];
`ifdef KBD_PORT_TYPEMATIC_FILTER_EN
    exp_q = '{8'h61, 8'hE1, 8'h61};
`else
    exp_q = '{8'h61, 8'h61, 8'h61, 8'hE1, 8'h61};
`endif
    port_wr(8'hFF, 8'h01);
    for (int i = 0; i < 3; i++) key(8'h1C, 8'h61);
    key(8'hF0, 8'h00);
    key(8'h1C, 8'h61);
    key(8'h1C, 8'h61);
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'(8'h80 + exp_q.size())) begin errs++; $display("FAIL tm_stat got %h want %h", d, 8'(8'h80 + exp_q.size())); end
    foreach (exp_q[i]) begin
      port_rd(8'hFE, d);
      vecs++; if (d !== exp_q[i]) begin errs++; $display("FAIL tm_entry[%0d] got %h want %h", i, d, exp_q[i]); end
    end
    port_rd(8'hFF, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL tm_empty got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_overflow();
    test_full_push_pop();
    test_intr();
    test_typematic();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
